// File: rtl/key_debounce_if.sv
// Key-side bundle for key_debounce: raw active-low keys in, conditioned levels and pulses out.
interface key_debounce_if #(
   parameter int unsigned NUM_KEYS = 2
);
   logic [NUM_KEYS-1:0] key;
   logic [NUM_KEYS-1:0] key_down;
   logic [NUM_KEYS-1:0] press_p;
   logic [NUM_KEYS-1:0] release_p;
   logic [NUM_KEYS-1:0] long_p;

   modport master (
      output key,
      input  key_down,
      input  press_p,
      input  release_p,
      input  long_p
   );

   modport slave (
      input  key,
      output key_down,
      output press_p,
      output release_p,
      output long_p
   );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, per-key debounce FSM, registered level and
// single-cycle press / release / long-press pulses.
module key_debounce #(
   parameter int unsigned NUM_KEYS        = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LONG_CYCLES     = 50000000
) (
   input logic           clk_i,
   input logic           rst_i,
   key_debounce_if.slave bus_io
);

   localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HoldW = $clog2(LONG_CYCLES);

   localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

   localparam logic [1:0] StIdle        = 2'd0;
   localparam logic [1:0] StPressWait   = 2'd1;
   localparam logic [1:0] StHeld        = 2'd2;
   localparam logic [1:0] StReleaseWait = 2'd3;

   logic [NUM_KEYS-1:0] down_w;
   logic [NUM_KEYS-1:0] press_w;
   logic [NUM_KEYS-1:0] release_w;
   logic [NUM_KEYS-1:0] long_w;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      logic [1:0]       sync_q;
      logic             key_s;
      logic [1:0]       state_q, state_d;
      logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
      logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
      logic             long_done_q, long_done_d;
      logic             down_q, down_d;
      logic             press_q, press_d;
      logic             release_q, release_d;
      logic             long_q, long_d;

      // Synchroniser resets to the released level so a held key is seen as a fresh press.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            sync_q <= 2'b11;
         end else begin
            sync_q <= {sync_q[0], bus_io.key[k]};
         end
      end

      assign key_s = ~sync_q[1];

      always_comb begin
         state_d     = state_q;
         deb_cnt_d   = deb_cnt_q;
         hold_cnt_d  = hold_cnt_q;
         long_done_d = long_done_q;
         down_d      = down_q;
         press_d     = 1'b0;
         release_d   = 1'b0;
         long_d      = 1'b0;
         case (state_q)
            StIdle: begin
               if (key_s) begin
                  state_d   = StPressWait;
                  deb_cnt_d = '0;
               end
            end
            StPressWait: begin
               if (!key_s) begin
                  state_d = StIdle;
               end else if (deb_cnt_q == DebLast) begin
                  state_d     = StHeld;
                  press_d     = 1'b1;
                  down_d      = 1'b1;
                  hold_cnt_d  = '0;
                  long_done_d = 1'b0;
               end else begin
                  deb_cnt_d = deb_cnt_q + DebW'(1);
               end
            end
            StHeld: begin
               if (!key_s) begin
                  state_d   = StReleaseWait;
                  deb_cnt_d = '0;
               end else if (hold_cnt_q == HoldLast) begin
                  // Saturated: fire once per hold only.
                  if (!long_done_q) begin
                     long_d      = 1'b1;
                     long_done_d = 1'b1;
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + HoldW'(1);
               end
            end
            StReleaseWait: begin
               if (key_s) begin
                  state_d = StHeld;
               end else if (deb_cnt_q == DebLast) begin
                  state_d   = StIdle;
                  release_d = 1'b1;
                  down_d    = 1'b0;
               end else begin
                  deb_cnt_d = deb_cnt_q + DebW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q     <= StIdle;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            down_q      <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
         end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            down_q      <= down_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
         end
      end

      assign down_w[k]    = down_q;
      assign press_w[k]   = press_q;
      assign release_w[k] = release_q;
      assign long_w[k]    = long_q;
   end

   assign bus_io.key_down  = down_w;
   assign bus_io.press_p   = press_w;
   assign bus_io.release_p = release_w;
   assign bus_io.long_p    = long_w;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10, two keys.
module tb_key_debounce;

   logic clk_i = 1'b0;
   logic rst_i;
   int   n_checks = 0;
   int   n_errors = 0;

   key_debounce_if #(.NUM_KEYS(2)) kif ();

   key_debounce #(
      .NUM_KEYS       (2),
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES    (10)
   ) u_dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus_io(kif.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, expected %b (down,press,release,long x2)", tag, got, exp);
      end
   endtask

   function automatic logic in_rng(input int e, input int lo, input int hi);
      return (e >= lo) && (e <= hi);
   endfunction

   function automatic logic [7:0] pk(input logic [1:0] d, input logic [1:0] p,
                                     input logic [1:0] r, input logic [1:0] l);
      return {d, p, r, l};
   endfunction

   // Drive one edge's inputs, clock it, then compare outputs 1 time unit after the edge.
   task automatic step(input string tag, input int e, input logic [1:0] key, input logic rst,
                       input logic [7:0] exp);
      kif.key = key;
      rst_i   = rst;
      @(posedge clk_i);
      #1;
      check_eq($sformatf("%s e%0d", tag, e),
               {kif.key_down, kif.press_p, kif.release_p, kif.long_p}, exp);
   endtask

   initial begin
      kif.key = 2'b11;
      rst_i   = 1'b1;

      for (int e = 1; e <= 3; e++) step("reset", e, 2'b11, 1'b1, 8'h00);
      for (int e = 1; e <= 3; e++) step("idle", e, 2'b11, 1'b0, 8'h00);

      // Clean press and release, short hold.
      for (int e = 1; e <= 22; e++)
         step("clean", e, (e <= 12) ? 2'b10 : 2'b11, 1'b0,
              pk({1'b0, in_rng(e, 7, 18)}, {1'b0, e == 7}, {1'b0, e == 19}, 2'b00));

      // Press bounce never reaches PRESS_P.
      for (int e = 1; e <= 14; e++)
         step("bounce", e, (in_rng(e, 1, 3) || in_rng(e, 5, 7)) ? 2'b10 : 2'b11, 1'b0,
              8'h00);

      // Release glitch while held is absorbed; hold count freezes, so no long press.
      for (int e = 1; e <= 26; e++)
         step("glitch", e, (e <= 9 || in_rng(e, 12, 16)) ? 2'b10 : 2'b11, 1'b0,
              pk({1'b0, in_rng(e, 7, 22)}, {1'b0, e == 7}, {1'b0, e == 23}, 2'b00));

      // Long press: exactly one LONG_P.
      for (int e = 1; e <= 40; e++)
         step("long", e, (e <= 30) ? 2'b10 : 2'b11, 1'b0,
              pk({1'b0, in_rng(e, 7, 36)}, {1'b0, e == 7}, {1'b0, e == 37},
                 {1'b0, e == 17}));

      // Simultaneous press, staggered release.
      for (int e = 1; e <= 24; e++)
         step("dual", e, {(e > 14), (e > 12)}, 1'b0,
              pk({in_rng(e, 7, 20), in_rng(e, 7, 18)}, {e == 7, e == 7},
                 {e == 21, e == 19}, 2'b00));

      // Reset mid-hold with the key kept low: no RELEASE_P, fresh press afterwards.
      for (int e = 1; e <= 30; e++)
         step("rsthold", e, (e <= 20) ? 2'b10 : 2'b11, in_rng(e, 10, 11),
              pk({1'b0, in_rng(e, 7, 9) || in_rng(e, 18, 26)},
                 {1'b0, e == 7 || e == 18}, {1'b0, e == 27}, 2'b00));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
